// File: rtl/adj_pixel_fetch_pkg.sv
// Shared constants for the FAST9 matcher front end: image geometry,
// neighbour offset table and the fetch FSM state type.
package fast9_pkg;

  localparam int IMG_W  = 320;
  localparam int IMG_H  = 240;
  localparam int ADDR_W = 17;

  // Neighbour k order: clockwise from the top-left pixel, ending at the left pixel.
  localparam int NB_DX [8] = '{-1,  0,  1,  1,  1,  0, -1, -1};
  localparam int NB_DY [8] = '{-1, -1, -1,  0,  1,  1,  1,  0};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/adj_pixel_fetch_if.sv
// Request/response and frame-buffer read port of the neighbour fetcher.
interface adj_pixel_fetch_if #(parameter int ADDR_W = fast9_pkg::ADDR_W);
  logic              start;
  logic [8:0]        ptX;
  logic [7:0]        ptY;
  logic              busy;
  logic              fbRdEn;
  logic [ADDR_W-1:0] fbAddr;
  logic [7:0]        fbRdData;
  logic [63:0]       adjFBPixel;
  logic              adjValid;

  modport master (
    output start, ptX, ptY, fbRdData,
    input  busy, fbRdEn, fbAddr, adjFBPixel, adjValid
  );

  modport slave (
    input  start, ptX, ptY, fbRdData,
    output busy, fbRdEn, fbAddr, adjFBPixel, adjValid
  );
endinterface

// File: rtl/adj_pixel_fetch_addr_gen.sv
// Combinational neighbour address: offset the point by entry k of the
// offset table, clamp to the image, then linearise row-major.
module fb_addr_gen
  import fast9_pkg::NB_DX, fast9_pkg::NB_DY;
#(
  parameter int IMG_W  = 320,
  parameter int IMG_H  = 240,
  parameter int ADDR_W = 17
) (
  input  logic [8:0]        ptX,
  input  logic [7:0]        ptY,
  input  logic [2:0]        k,
  output logic [ADDR_W-1:0] addr
);

  int nx, ny;

  always_comb begin
    nx = int'({23'd0, ptX}) + NB_DX[k];
    ny = int'({24'd0, ptY}) + NB_DY[k];
    if (nx < 0)      nx = 0;
    if (nx > IMG_W-1) nx = IMG_W - 1;
    if (ny < 0)      ny = 0;
    if (ny > IMG_H-1) ny = IMG_H - 1;
    addr = ADDR_W'(ny * IMG_W + nx);
  end

endmodule

// File: rtl/adj_pixel_fetch.sv
// Reads the 8 neighbours of a feature point from the frame buffer and
// presents them packed as one 64-bit word with a single-cycle valid.
module adj_pixel_fetch #(
  parameter int IMG_W  = fast9_pkg::IMG_W,
  parameter int IMG_H  = fast9_pkg::IMG_H,
  parameter int ADDR_W = fast9_pkg::ADDR_W
) (
  input logic               clk,
  input logic               rst_n,
  adj_pixel_fetch_if.slave  bus
);
  import fast9_pkg::state_t, fast9_pkg::IDLE, fast9_pkg::FETCH,
         fast9_pkg::DRAIN, fast9_pkg::DONE;

  if (IMG_W * IMG_H > 2**ADDR_W) begin : gBadGeom
    $error("adj_pixel_fetch: IMG_W*IMG_H does not fit in ADDR_W bits");
  end

  state_t            state;
  logic [2:0]        kCnt;
  logic [8:0]        ptXL;
  logic [7:0]        ptYL;
  logic [6:0][7:0]   shadow;
  logic              busyR, rdEnR, validR;
  logic [ADDR_W-1:0] addrR;
  logic [63:0]       pixR;

  logic              canAccept;
  logic [8:0]        satX, agX;
  logic [7:0]        satY, agY;
  logic [2:0]        agK;
  logic [ADDR_W-1:0] agAddr;

  assign canAccept = (state == IDLE) || (state == DONE);
  assign satX = (32'(bus.ptX) >= IMG_W) ? 9'(IMG_W - 1) : bus.ptX;
  assign satY = (32'(bus.ptY) >= IMG_H) ? 8'(IMG_H - 1) : bus.ptY;

  // On accept the first address comes straight from the incoming point so
  // fbRdEn can rise in the very next cycle; afterwards from the latched one.
  assign agX = canAccept ? satX : ptXL;
  assign agY = canAccept ? satY : ptYL;
  assign agK = canAccept ? 3'd0 : kCnt + 3'd1;

  fb_addr_gen #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)) uAddrGen (
    .ptX (agX),
    .ptY (agY),
    .k   (agK),
    .addr(agAddr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      kCnt   <= '0;
      ptXL   <= '0;
      ptYL   <= '0;
      shadow <= '0;
      busyR  <= 1'b0;
      rdEnR  <= 1'b0;
      validR <= 1'b0;
      addrR  <= '0;
      pixR   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          validR <= 1'b0;
          if (bus.start) begin
            ptXL  <= satX;
            ptYL  <= satY;
            kCnt  <= 3'd0;
            rdEnR <= 1'b1;
            addrR <= agAddr;
            busyR <= 1'b1;
            state <= FETCH;
          end else begin
            rdEnR <= 1'b0;
            busyR <= 1'b0;
            state <= IDLE;
          end
        end
        FETCH: begin
          // Data on the bus now belongs to the read issued last cycle.
          if (kCnt != 3'd0) shadow[kCnt - 3'd1] <= bus.fbRdData;
          if (kCnt == 3'd7) begin
            rdEnR <= 1'b0;
            state <= DRAIN;
          end else begin
            kCnt  <= kCnt + 3'd1;
            addrR <= agAddr;
          end
        end
        DRAIN: begin
          pixR   <= {bus.fbRdData, shadow};
          validR <= 1'b1;
          busyR  <= 1'b0;
          state  <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy       = busyR;
  assign bus.fbRdEn     = rdEnR;
  assign bus.fbAddr     = addrR;
  assign bus.adjFBPixel = pixR;
  assign bus.adjValid   = validR;

endmodule

// File: tb/tb_adj_pixel_fetch.sv
// Self-checking bench for adj_pixel_fetch: spec vectors, multi-cycle corner
// sequences and random points against a clamp-and-linearise reference.
module tb_adj_pixel_fetch;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  adj_pixel_fetch_if #(.ADDR_W(17)) bus();

  adj_pixel_fetch #(.IMG_W(320), .IMG_H(240), .ADDR_W(17)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Frame buffer: mem[a] = a[7:0], one-cycle read latency.
  always @(posedge clk) if (bus.fbRdEn) bus.fbRdData <= bus.fbAddr[7:0];

  int nRun = 0;
  int nFail = 0;

  typedef logic [7:0][16:0] addrs_t;
  typedef struct { int x; int y; int a[8]; } vec_t;
  vec_t vecs[3];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nRun++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic addrs_t model(input int x, input int y);
    int dx[8] = '{-1, 0, 1, 1, 1, 0, -1, -1};
    int dy[8] = '{-1, -1, -1, 0, 1, 1, 1, 0};
    int sx, sy, nx, ny;
    addrs_t r;
    sx = (x > 319) ? 319 : x;
    sy = (y > 239) ? 239 : y;
    for (int k = 0; k < 8; k++) begin
      nx = sx + dx[k];
      ny = sy + dy[k];
      nx = (nx < 0) ? 0 : (nx > 319) ? 319 : nx;
      ny = (ny < 0) ? 0 : (ny > 239) ? 239 : ny;
      r[k] = 17'(ny * 320 + nx);
    end
    return r;
  endfunction

  function automatic logic [63:0] pixOf(input addrs_t a);
    logic [63:0] p;
    for (int k = 0; k < 8; k++) p[8*k +: 8] = a[k][7:0];
    return p;
  endfunction

  function automatic addrs_t toAddrs(input vec_t v);
    addrs_t r;
    for (int k = 0; k < 8; k++) r[k] = 17'(v.a[k]);
    return r;
  endfunction

  // Called at a negedge with the DUT idle; that cycle is cycle 0.
  // pulseAt > 0 re-asserts start with (50,50) in that cycle.
  task automatic fetch(input int x, input int y, input addrs_t ea, input int pulseAt);
    bus.start = 1'b1;
    bus.ptX = 9'(x);
    bus.ptY = 8'(y);
    @(negedge clk);
    for (int c = 1; c <= 13; c++) begin
      if (c <= 8) begin
        chk($sformatf("rdEn c%0d", c), 64'(bus.fbRdEn), 64'd1);
        chk($sformatf("addr k%0d", c-1), 64'(bus.fbAddr), 64'(ea[c-1]));
        chk($sformatf("busy c%0d", c), 64'(bus.busy), 64'd1);
      end else if (c == 9) begin
        chk("rdEn drain", 64'(bus.fbRdEn), 64'd0);
        chk("busy drain", 64'(bus.busy), 64'd1);
      end
      if (c == 10) begin
        chk("adjValid", 64'(bus.adjValid), 64'd1);
        chk("adjFBPixel", bus.adjFBPixel, pixOf(ea));
        chk("busy done", 64'(bus.busy), 64'd0);
      end else begin
        chk($sformatf("noValid c%0d", c), 64'(bus.adjValid), 64'd0);
      end
      if (c == pulseAt) begin
        bus.start = 1'b1;
        bus.ptX = 9'd50;
        bus.ptY = 8'd50;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    addrs_t p1, p2;
    vecs[0] = '{10, 10, '{2889, 2890, 2891, 3211, 3531, 3530, 3529, 3209}};
    vecs[1] = '{0, 0, '{0, 0, 1, 1, 321, 320, 320, 0}};
    vecs[2] = '{319, 239, '{76478, 76479, 76479, 76799, 76799, 76799, 76798, 76798}};

    bus.start = 1'b0;
    bus.ptX = '0;
    bus.ptY = '0;
    repeat (2) @(negedge clk);
    chk("rst busy", 64'(bus.busy), 64'd0);
    chk("rst rdEn", 64'(bus.fbRdEn), 64'd0);
    chk("rst addr", 64'(bus.fbAddr), 64'd0);
    chk("rst pix", bus.adjFBPixel, 64'd0);
    chk("rst valid", 64'(bus.adjValid), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Spec vectors: interior and both corners
    for (int i = 0; i < 3; i++) fetch(vecs[i].x, vecs[i].y, toAddrs(vecs[i]), 0);

    // Start while busy is ignored
    fetch(10, 10, toAddrs(vecs[0]), 4);

    // Back-to-back with start held high, new point presented in DONE
    p1 = toAddrs(vecs[0]);
    p2 = toAddrs(vecs[1]);
    bus.start = 1'b1;
    bus.ptX = 9'd10;
    bus.ptY = 8'd10;
    @(negedge clk);
    for (int c = 1; c <= 21; c++) begin
      if (c == 10) begin
        chk("b2b valid1", 64'(bus.adjValid), 64'd1);
        chk("b2b pix1", bus.adjFBPixel, pixOf(p1));
        bus.ptX = 9'd0;
        bus.ptY = 8'd0;
      end
      if (c == 11) begin
        chk("b2b rdEn2", 64'(bus.fbRdEn), 64'd1);
        chk("b2b addr2", 64'(bus.fbAddr), 64'd0);
        bus.start = 1'b0;
      end
      if (c >= 11 && c <= 19) begin
        chk($sformatf("b2b hold c%0d", c), bus.adjFBPixel, pixOf(p1));
        chk($sformatf("b2b noValid c%0d", c), 64'(bus.adjValid), 64'd0);
      end
      if (c == 20) begin
        chk("b2b valid2", 64'(bus.adjValid), 64'd1);
        chk("b2b pix2", bus.adjFBPixel, pixOf(p2));
      end
      @(negedge clk);
    end

    // Reset in the middle of a fetch
    bus.start = 1'b1;
    bus.ptX = 9'd10;
    bus.ptY = 8'd10;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid-rst busy", 64'(bus.busy), 64'd0);
    chk("mid-rst rdEn", 64'(bus.fbRdEn), 64'd0);
    chk("mid-rst addr", 64'(bus.fbAddr), 64'd0);
    chk("mid-rst pix", bus.adjFBPixel, 64'd0);
    chk("mid-rst valid", 64'(bus.adjValid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      chk($sformatf("post-rst noValid %0d", c), 64'(bus.adjValid), 64'd0);
      @(negedge clk);
    end
    fetch(10, 10, toAddrs(vecs[0]), 0);

    // Random points, including out-of-range coordinates that saturate
    for (int i = 0; i < 25; i++) begin
      int rx, ry;
      rx = int'($urandom_range(0, 335));
      ry = int'($urandom_range(0, 255));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      fetch(rx, ry, model(rx, ry), (i % 4 == 0) ? int'($urandom_range(1, 9)) : 0);
    end

    $display("[TB] %0d tests run, %0d failed", nRun, nFail);
    $finish;
  end

endmodule
